// File: rtl/wb_data_ram_slave_if.sv
// ---------------------------------------------------------------
// wb_data_ram_slave_if: Wishbone classic bus bundle, rev 1.0
// ---------------------------------------------------------------
`default_nettype none

interface wb_data_ram_slave_if;
  logic [31:0] wb_adr_i;
  logic [31:0] wb_dat_i;
  logic        wb_we_i;
  logic [3:0]  wb_sel_i;
  logic        wb_stb_i;
  logic        wb_cyc_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;
  logic        miss_o;

  modport master (
    output wb_adr_i, wb_dat_i, wb_we_i, wb_sel_i, wb_stb_i, wb_cyc_i,
    input  wb_dat_o, wb_ack_o, miss_o
  );

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_we_i, wb_sel_i, wb_stb_i, wb_cyc_i,
    output wb_dat_o, wb_ack_o, miss_o
  );
endinterface

`default_nettype wire

// File: rtl/wb_data_ram_slave.sv
// ---------------------------------------------------------------
// wb_data_ram_slave: Wishbone data RAM slave with wait states, rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module wb_data_ram_slave #(
  parameter int          ADDR_WIDTH  = 10,
  parameter int          WAIT_STATES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  wire logic          clk,
  input  wire logic          rst,
  wb_data_ram_slave_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  localparam int         TAG_LSB   = ADDR_WIDTH + 2;
  localparam int         DEPTH     = 1 << ADDR_WIDTH;
  localparam logic [3:0] WCNT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  state_t                  state;
  logic [3:0]              wcnt;
  logic [ADDR_WIDTH-1:0]   idx_lat;
  logic [31:0]             dat_lat;
  logic [3:0]              sel_lat;
  logic                    we_lat;
  logic                    hit_lat;
  logic                    ack;
  logic [31:0]             rdata;
  logic                    miss;

  logic [31:0]             mem [DEPTH];

  logic                    req;
  logic                    in_hit;
  logic                    enter_ack;
  logic [ADDR_WIDTH-1:0]   acc_idx;
  logic [31:0]             acc_dat;
  logic [3:0]              acc_sel;
  logic                    acc_we;
  logic                    acc_hit;
  logic                    unused_adr_bits;

  assign req             = bus.wb_stb_i & bus.wb_cyc_i;
  assign in_hit          = (bus.wb_adr_i[31:TAG_LSB] == BASE_ADDR[31:TAG_LSB]);
  assign unused_adr_bits = ^bus.wb_adr_i[1:0];

  // With zero wait states the access completes on the edge that sees the
  // request, so the live bus values stand in for the not-yet-latched copies.
  always_comb begin
    acc_idx = idx_lat;
    acc_dat = dat_lat;
    acc_sel = sel_lat;
    acc_we  = we_lat;
    acc_hit = hit_lat;
    if (state == S_IDLE) begin
      acc_idx = bus.wb_adr_i[ADDR_WIDTH+1:2];
      acc_dat = bus.wb_dat_i;
      acc_sel = bus.wb_sel_i;
      acc_we  = bus.wb_we_i;
      acc_hit = in_hit;
    end
    enter_ack = 1'b0;
    if (state == S_IDLE && req && WAIT_STATES == 0) begin
      enter_ack = 1'b1;
    end
    if (state == S_WAIT && req && wcnt == 4'd0) begin
      enter_ack = 1'b1;
    end
  end

  // RAM contents are intentionally left out of reset.
  always_ff @(posedge clk) begin
    if (!rst && enter_ack && acc_hit && acc_we) begin
      for (int i = 0; i < 4; i++) begin
        if (acc_sel[i]) begin
          mem[acc_idx][8*i +: 8] <= acc_dat[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      wcnt    <= 4'd0;
      idx_lat <= '0;
      dat_lat <= 32'h0;
      sel_lat <= 4'h0;
      we_lat  <= 1'b0;
      hit_lat <= 1'b0;
      ack     <= 1'b0;
      rdata   <= 32'h0;
      miss    <= 1'b0;
    end else begin
      ack   <= 1'b0;
      rdata <= 32'h0;
      miss  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req) begin
            idx_lat <= bus.wb_adr_i[ADDR_WIDTH+1:2];
            dat_lat <= bus.wb_dat_i;
            sel_lat <= bus.wb_sel_i;
            we_lat  <= bus.wb_we_i;
            hit_lat <= in_hit;
            if (WAIT_STATES == 0) begin
              state <= S_ACK;
            end else begin
              wcnt  <= WCNT_INIT;
              state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (!req) begin
            state <= S_IDLE;
          end else if (wcnt == 4'd0) begin
            state <= S_ACK;
          end else begin
            wcnt <= wcnt - 4'd1;
          end
        end
        S_ACK: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
      if (enter_ack) begin
        ack   <= 1'b1;
        miss  <= ~acc_hit;
        rdata <= (acc_hit && !acc_we) ? mem[acc_idx] : 32'h0;
      end
    end
  end

  assign bus.wb_ack_o = ack;
  assign bus.wb_dat_o = rdata;
  assign bus.miss_o   = miss;

endmodule

`default_nettype wire

// File: tb/tb_wb_data_ram_slave.sv
// ---------------------------------------------------------------
// tb_wb_data_ram_slave: scoreboard bench for two wait-state settings, rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module tb_wb_data_ram_slave;

  localparam int D2 = 0;  // WAIT_STATES = 2
  localparam int D0 = 1;  // WAIT_STATES = 0

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wb_data_ram_slave_if b2 ();
  wb_data_ram_slave_if b0 ();

  wb_data_ram_slave #(.ADDR_WIDTH(10), .WAIT_STATES(2), .BASE_ADDR(32'h0)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (b2)
  );

  wb_data_ram_slave #(.ADDR_WIDTH(10), .WAIT_STATES(0), .BASE_ADDR(32'h0)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (b0)
  );

  typedef struct packed {
    logic [31:0] dat;
    logic        miss;
  } exp_t;

  exp_t        q2[$];
  exp_t        q0[$];
  logic [31:0] mdl2 [int];
  logic [31:0] mdl0 [int];
  int          checks   = 0;
  int          failures = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic ack_of(input int d);
    return (d == D2) ? b2.wb_ack_o : b0.wb_ack_o;
  endfunction

  task automatic drive(input int d, input logic s, input logic we, input logic [31:0] adr,
                       input logic [31:0] dat, input logic [3:0] sel);
    if (d == D2) begin
      b2.wb_stb_i = s; b2.wb_cyc_i = s; b2.wb_we_i = we;
      b2.wb_adr_i = adr; b2.wb_dat_i = dat; b2.wb_sel_i = sel;
    end else begin
      b0.wb_stb_i = s; b0.wb_cyc_i = s; b0.wb_we_i = we;
      b0.wb_adr_i = adr; b0.wb_dat_i = dat; b0.wb_sel_i = sel;
    end
  endtask

  // Reference model: default BASE_ADDR 0 and 1024 words, so the tag is adr[31:12].
  task automatic expect_access(input int d, input logic we, input logic [31:0] adr,
                               input logic [31:0] dat, input logic [3:0] sel);
    logic        hit;
    int          idx;
    logic [31:0] cur;
    exp_t        e;
    hit = (adr[31:12] == 20'h0);
    idx = int'(adr[11:2]);
    cur = 32'h0;
    if (d == D2 && mdl2.exists(idx)) cur = mdl2[idx];
    if (d == D0 && mdl0.exists(idx)) cur = mdl0[idx];
    e.dat  = 32'h0;
    e.miss = ~hit;
    if (hit && we) begin
      for (int i = 0; i < 4; i++) begin
        if (sel[i]) cur[8*i +: 8] = dat[8*i +: 8];
      end
      if (d == D2) mdl2[idx] = cur; else mdl0[idx] = cur;
    end
    if (hit && !we) e.dat = cur;
    if (d == D2) q2.push_back(e); else q0.push_back(e);
  endtask

  // Entered just after the edge that starts cycle 0; leaves just after the
  // edge that starts the cycle following one idle cycle.
  task automatic wait_ack(input int d, input int abort_cyc);
    int lat;
    int got;
    int pulses;
    lat    = (d == D2) ? 3 : 1;
    got    = -1;
    pulses = 0;
    for (int c = 0; c < lat + 6; c++) begin
      @(negedge clk);
      if (ack_of(d)) begin
        pulses++;
        if (got < 0) got = c;
      end
      @(posedge clk);
      #1;
      if (got == c || abort_cyc == c + 1) drive(d, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      if (got >= 0 && c > got) break;
    end
    drive(d, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    check("ack_cycle", got, (abort_cyc > 0) ? -1 : lat);
    check("ack_pulses", pulses, (abort_cyc > 0) ? 0 : 1);
  endtask

  task automatic access(input int d, input logic we, input logic [31:0] adr,
                        input logic [31:0] dat, input logic [3:0] sel, input int abort_cyc);
    if (abort_cyc == 0) expect_access(d, we, adr, dat, sel);
    drive(d, 1'b1, we, adr, dat, sel);
    wait_ack(d, abort_cyc);
  endtask

  always @(negedge clk) begin : mon2
    exp_t e;
    if (!rst && b2.wb_ack_o) begin
      if (q2.size() == 0) begin
        check("dut2_unexpected_ack", 32'd1, 32'd0);
      end else begin
        e = q2.pop_front();
        check("dut2_dat", b2.wb_dat_o, e.dat);
        check("dut2_miss", {31'b0, b2.miss_o}, {31'b0, e.miss});
      end
    end
  end

  always @(negedge clk) begin : mon0
    exp_t e;
    if (!rst && b0.wb_ack_o) begin
      if (q0.size() == 0) begin
        check("dut0_unexpected_ack", 32'd1, 32'd0);
      end else begin
        e = q0.pop_front();
        check("dut0_dat", b0.wb_dat_o, e.dat);
        check("dut0_miss", {31'b0, b0.miss_o}, {31'b0, e.miss});
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    drive(D2, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive(D0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);

    // Request held through reset must not be served until reset releases.
    expect_access(D2, 1'b1, 32'h30, 32'hCAFE_F00D, 4'hF);
    drive(D2, 1'b1, 1'b1, 32'h30, 32'hCAFE_F00D, 4'hF);
    repeat (2) begin
      @(negedge clk);
      check("rst_ack", {31'b0, b2.wb_ack_o}, 32'd0);
      check("rst_dat", b2.wb_dat_o, 32'h0);
      check("rst_miss", {31'b0, b2.miss_o}, 32'd0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    wait_ack(D2, 0);

    access(D2, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 0);
    access(D2, 1'b0, 32'h10, 32'h0, 4'hF, 0);

    access(D2, 1'b1, 32'h10, 32'h1122_3344, 4'hF, 0);
    access(D2, 1'b1, 32'h10, 32'hAABB_CCDD, 4'b0101, 0);
    access(D2, 1'b0, 32'h10, 32'h0, 4'hF, 0);

    access(D2, 1'b1, 32'h20, 32'h0000_0077, 4'hF, 0);
    access(D2, 1'b1, 32'h20, 32'h0000_0005, 4'hF, 1);
    access(D2, 1'b0, 32'h20, 32'h0, 4'hF, 0);

    access(D2, 1'b0, 32'h0001_0000, 32'h0, 4'hF, 0);
    access(D2, 1'b1, 32'h0001_0010, 32'hFFFF_FFFF, 4'hF, 0);
    access(D2, 1'b0, 32'h10, 32'h0, 4'hF, 0);

    access(D2, 1'b1, 32'h30, 32'h1234_5678, 4'b0000, 0);
    access(D2, 1'b0, 32'h33, 32'h0, 4'b0000, 0);

    for (int k = 0; k < 8; k++) begin
      access(D2, 1'b1, 32'h40 + 32'(4 * k), $urandom, 4'hF, 0);
    end
    for (int k = 0; k < 12; k++) begin
      access(D2, 1'($urandom_range(0, 1)), 32'h40 + 32'(4 * $urandom_range(0, 7)),
             $urandom, 4'($urandom_range(0, 15)), 0);
    end

    access(D0, 1'b1, 32'h4, 32'h1234_5678, 4'hF, 0);
    access(D0, 1'b0, 32'h4, 32'h0, 4'hF, 0);
    access(D0, 1'b1, 32'h8, 32'h0BAD_F00D, 4'hF, 0);
    access(D0, 1'b1, 32'hC, 32'h5A5A_A5A5, 4'b1001, 0);
    access(D0, 1'b0, 32'h4, 32'h0, 4'hF, 0);
    access(D0, 1'b0, 32'h8, 32'h0, 4'hF, 0);
    access(D0, 1'b1, 32'h8, 32'hFFFF_0000, 4'b1100, 0);
    access(D0, 1'b0, 32'h8, 32'h0, 4'hF, 0);
    access(D0, 1'b0, 32'h0001_0004, 32'h0, 4'hF, 0);

    repeat (3) @(posedge clk);
    check("q2_drained", q2.size(), 32'd0);
    check("q0_drained", q0.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
